inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch stage feeding the control unit and register file of the RISC-V core. It holds the program counter and fetches one 32-bit instruction at a time over a wait-state-tolerant instruction-memory handshake. It presents the instruction to decode/control with a valid/ready handshake. When decode consumes the instruction, it takes the next-PC decision from the control unit (`PCSel`) and the ALU-computed target.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded by reset; must be 4-byte aligned.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_req` out 1: fetch request to instruction memory.
- `imem_addr` out 32: fetch address; always equals `pc` while `imem_req`=1.
- `imem_ack` in 1: memory returns data this cycle.
- `imem_rdata` in 32: instruction word; valid when `imem_ack`=1.
- `inst` out 32: registered instruction to the control unit and decode.
- `pc` out 32: address of `inst` while `inst_valid`=1; otherwise the address being fetched.
- `inst_valid` out 1: `inst`/`pc` hold a fetched instruction.
- `inst_ready` in 1: consumer accepts `inst` this cycle.
- `PCSel` in 1: next-PC select (0 = pc+4, 1 = `alu_target`); sampled only at handshake.
- `alu_target` in 32: branch/jump target from the ALU.
- `fetch_fault` out 1: misaligned-target fault flag (see Configuration).

## Operation
- States: FETCH, VALID, FAULT.
- Reset (`rst`=1 at edge):
  - state ← FETCH, `pc` ← `RESET_PC`, `inst` ← 32'h0000_0013 (NOP).
  - `inst_valid`=0, `fetch_fault`=0.
  - `imem_req`=0 while `rst` is high.
- FETCH:
  - `imem_req`=1, `imem_addr`=`pc`; both held stable until ack.
  - At an edge with `imem_ack`=1: `inst` ← `imem_rdata`, state ← VALID.
- VALID:
  - `inst_valid`=1, `imem_req`=0; `inst` and `pc` held while `inst_ready`=0.
  - At an edge with `inst_ready`=1, the next target is computed:
    - `PCSel`=0: pc + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
    - `PCSel`=1: {`alu_target`[31:1], 1'b0}; bit 0 is always cleared (JALR rule).
  - If the target has bit 1 = 1, the FAULT rule applies (see Configuration).
  - Otherwise `pc` ← target and state ← FETCH.
- FAULT: `imem_req`=0, `inst_valid`=0, `fetch_fault`=1; sticky until `rst`.
- `imem_ack` outside FETCH is ignored; `imem_rdata` is not sampled.
- `inst_ready` outside VALID is ignored.
- `PCSel` and `alu_target` are don't-care except at the accepting edge.

## Timing
- `imem_req` rises the first cycle after `rst` falls.
- Zero-wait memory (`imem_ack`=1 in the first request cycle):
  - `inst_valid` rises the cycle after the request cycle.
- Throughput: one instruction per 2 cycles minimum.
  - Each accept costs one VALID cycle plus at least one FETCH cycle.
- Wait states extend FETCH one cycle each; no timeout.
- Accepting edge to new request: the next cycle shows `imem_req`=1 with the new `imem_addr`.
- `rst` mid-operation wins over any simultaneous ack or handshake.
  - Example: `rst`=1 coincident with `imem_ack`=1 gives the reset values above; the returned word is discarded.
- All outputs are registered or decoded from state/registers only; no input-to-output combinational path.

## Configuration
- Macro: `INST_FETCH_MISALIGN_TRAP_EN`.
- Defined:
  - A target with bit 1 = 1 enters FAULT.
  - `pc` ← the offending target with bit 0 cleared, so the PC is observable.
  - `fetch_fault`=1 from the next cycle onward.
- Undefined:
  - Bit 1 is also cleared silently (target & ~3); FAULT is unreachable.
  - `fetch_fault` is tied to 0.

## Test plan
- Reset then zero-wait memory, `inst_ready`=1, `PCSel`=0:
  - `imem_addr` sequence 0x0, 0x4, 0x8, with `inst_valid` high every second cycle.
  - `inst` matches memory words.
- Memory inserts 3 wait cycles on the fetch at 0x4:
  - `imem_req`/`imem_addr`=0x4 held for 4 cycles.
  - `inst` is updated only at the ack edge.
  - `inst_valid` stays 0 throughout.
- Backpressure: `inst_ready`=0 for 5 cycles in VALID.
  - `inst`, `pc`, `inst_valid`=1 stable; no `imem_req`.
  - Then `inst_ready`=1 gives next `imem_addr`=pc+4.
- Redirect with `PCSel`=1, `alu_target`=0x0000_0101:
  - Next `imem_addr`=0x0000_0100.
  - `PCSel`=1 with `inst_ready`=0 has no effect.
- Misaligned target `alu_target`=0x0000_0206:
  - Macro defined: `fetch_fault`=1, `pc`=0x206, no further requests until `rst`; then `pc`=`RESET_PC`, `fetch_fault`=0.
  - Macro undefined: `imem_addr`=0x204.
- Wrap and reset: `RESET_PC`=0xFFFF_FFFC, accept with `PCSel`=0 gives `imem_addr`=0x0.
  - `rst` asserted together with `imem_ack`: outputs return to reset values the next cycle and the word is discarded.

Source files
------------

// File: rtl/inst_fetch.sv
// inst_fetch: holds the program counter, fetches one 32-bit instruction at a time
// over a wait-state-tolerant memory handshake, and presents it to decode with valid/ready.
// Optional feature macro: INST_FETCH_MISALIGN_TRAP_EN. When it is defined, a next-PC
// target with bit 1 set enters a sticky FAULT state. When it is undefined, the target
// is silently word-aligned and fetch_fault is tied low.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        PCSel,
  input  logic [31:0] alu_target,
  output logic        fetch_fault
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST  = XLEN'(32'h0000_0013);
  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);
  localparam logic [XLEN-1:0] BIT0_MASK = ~XLEN'(1);
  localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_VALID = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic            req_q, req_d;
  logic            valid_q, valid_d;
  logic            fault_d;

  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] jmp_pc;
  logic [XLEN-1:0] target;

  // Next-PC candidate; only consumed at the accepting edge.
  always_comb begin
    seq_pc = pc_q + PC_STEP;
    jmp_pc = alu_target & BIT0_MASK;
    target = PCSel ? jmp_pc : seq_pc;
  end

  // Next-state, next-PC and next-output decode.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    req_d   = 1'b0;
    valid_d = 1'b0;
    fault_d = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          inst_d  = imem_rdata;
          state_d = S_VALID;
        end
      end
      S_VALID: begin
        if (inst_ready) begin
`ifdef INST_FETCH_MISALIGN_TRAP_EN
          pc_d    = target;
          state_d = target[1] ? S_FAULT : S_FETCH;
`else
          pc_d    = target & WORD_MASK;
          state_d = S_FETCH;
`endif
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
    req_d   = (state_d == S_FETCH);
    valid_d = (state_d == S_VALID);
    fault_d = (state_d == S_FAULT);
  end

  // State, PC, instruction and registered handshake flags; reset dominates everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      inst_q  <= NOP_INST;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      req_q   <= req_d;
      valid_q <= valid_d;
    end
  end

`ifdef INST_FETCH_MISALIGN_TRAP_EN
  logic fault_q;

  // Sticky fault flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign fetch_fault = fault_q;
`else
  logic unused_fault;
  assign unused_fault = fault_d;
  assign fetch_fault  = 1'b0;
`endif

  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign inst       = inst_q;
  assign inst_valid = valid_q;

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed and randomized scenarios for inst_fetch, checked against a
// transaction-level PC/memory model kept in the bench.
module tb_inst_fetch;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, imem_ack, inst_ready, PCSel;
  logic [31:0] imem_rdata, alu_target;
  logic        imem_req, inst_valid, fetch_fault;
  logic [31:0] imem_addr, inst, pc;

  logic        rst2, ack2, ready2, sel2;
  logic [31:0] rdata2, alu2;
  logic        req2, valid2, fault2;
  logic [31:0] addr2, inst2, pc2;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_inst;

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst(inst), .pc(pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .PCSel(PCSel),
    .alu_target(alu_target), .fetch_fault(fetch_fault)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst2), .imem_req(req2), .imem_addr(addr2),
    .imem_ack(ack2), .imem_rdata(rdata2), .inst(inst2), .pc(pc2),
    .inst_valid(valid2), .inst_ready(ready2), .PCSel(sel2),
    .alu_target(alu2), .fetch_fault(fault2)
  );

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; imem_ack = 1'b0; inst_ready = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    exp_pc = 32'h0; exp_inst = 32'h0000_0013;
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; inst_ready = 1'b0;
    PCSel = 1'b0; alu_target = 32'h0;
    tick(); tick();
    checks++;
    if ({imem_req, inst_valid, fetch_fault} !== 3'b000) begin
      failures++; $display("FAIL reset_flags got=%b exp=000", {imem_req, inst_valid, fetch_fault});
    end
    checks++;
    if (inst !== 32'h0000_0013) begin
      failures++; $display("FAIL reset_inst got=%h exp=00000013", inst);
    end
    checks++;
    if (pc !== 32'h0) begin
      failures++; $display("FAIL reset_pc got=%h exp=00000000", pc);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({imem_req, imem_addr, inst_valid} !== {1'b1, 32'h0, 1'b0}) begin
      failures++; $display("FAIL reset_first_req got=%h exp=%h", {imem_req, imem_addr, inst_valid}, {1'b1, 32'h0, 1'b0});
    end
    exp_pc = 32'h0; exp_inst = 32'h0000_0013;
  endtask

  task automatic test_zero_wait();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({imem_req, imem_addr, inst_valid} !== {1'b1, exp_pc, 1'b0}) begin
        failures++; $display("FAIL zw_req got=%h exp=%h", {imem_req, imem_addr, inst_valid}, {1'b1, exp_pc, 1'b0});
      end
      imem_ack = 1'b1; imem_rdata = mem_word(exp_pc);
      tick();
      imem_ack = 1'b0; exp_inst = mem_word(exp_pc);
      checks++;
      if ({inst_valid, imem_req, inst, pc} !== {1'b1, 1'b0, exp_inst, exp_pc}) begin
        failures++; $display("FAIL zw_valid got=%h exp=%h", {inst_valid, imem_req, inst, pc}, {1'b1, 1'b0, exp_inst, exp_pc});
      end
      inst_ready = 1'b1; PCSel = 1'b0;
      tick();
      inst_ready = 1'b0; exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_wait_states();
    apply_reset();
    imem_ack = 1'b1; imem_rdata = mem_word(32'h0);
    tick();
    imem_ack = 1'b0; exp_inst = mem_word(32'h0);
    inst_ready = 1'b1; PCSel = 1'b0;
    tick();
    inst_ready = 1'b0; exp_pc = 32'h4;
    for (int w = 0; w <= 3; w++) begin
      checks++;
      if ({imem_req, imem_addr, inst_valid, inst} !== {1'b1, 32'h4, 1'b0, exp_inst}) begin
        failures++; $display("FAIL ws_hold got=%h exp=%h", {imem_req, imem_addr, inst_valid, inst}, {1'b1, 32'h4, 1'b0, exp_inst});
      end
      imem_ack = (w == 3);
      imem_rdata = (w == 3) ? mem_word(32'h4) : 32'hBAD0_0000 + 32'(w);
      tick();
    end
    imem_ack = 1'b0; exp_inst = mem_word(32'h4);
    checks++;
    if ({inst_valid, inst, pc} !== {1'b1, exp_inst, 32'h4}) begin
      failures++; $display("FAIL ws_valid got=%h exp=%h", {inst_valid, inst, pc}, {1'b1, exp_inst, 32'h4});
    end
    inst_ready = 1'b1; PCSel = 1'b0;
    tick();
    inst_ready = 1'b0; exp_pc = 32'h8;
  endtask

  task automatic test_backpressure();
    imem_ack = 1'b1; imem_rdata = mem_word(exp_pc);
    tick();
    exp_inst = mem_word(exp_pc);
    for (int s = 0; s < 5; s++) begin
      checks++;
      if ({inst_valid, imem_req, inst, pc} !== {1'b1, 1'b0, exp_inst, exp_pc}) begin
        failures++; $display("FAIL bp_stall got=%h exp=%h", {inst_valid, imem_req, inst, pc}, {1'b1, 1'b0, exp_inst, exp_pc});
      end
      inst_ready = 1'b0; PCSel = 1'($urandom_range(0, 1)); alu_target = $urandom;
      imem_ack = 1'($urandom_range(0, 1)); imem_rdata = $urandom;
      tick();
    end
    imem_ack = 1'b0; inst_ready = 1'b1; PCSel = 1'b0;
    tick();
    inst_ready = 1'b0; exp_pc = exp_pc + 32'd4;
    checks++;
    if ({imem_req, imem_addr, inst_valid} !== {1'b1, exp_pc, 1'b0}) begin
      failures++; $display("FAIL bp_release got=%h exp=%h", {imem_req, imem_addr, inst_valid}, {1'b1, exp_pc, 1'b0});
    end
  endtask

  task automatic test_redirect();
    imem_ack = 1'b1; imem_rdata = mem_word(exp_pc);
    tick();
    imem_ack = 1'b0; exp_inst = mem_word(exp_pc);
    inst_ready = 1'b0; PCSel = 1'b1; alu_target = 32'h0000_0101;
    tick();
    checks++;
    if ({inst_valid, imem_req, pc} !== {1'b1, 1'b0, exp_pc}) begin
      failures++; $display("FAIL redir_noready got=%h exp=%h", {inst_valid, imem_req, pc}, {1'b1, 1'b0, exp_pc});
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0; PCSel = 1'b0; exp_pc = 32'h0000_0100;
    checks++;
    if ({imem_req, imem_addr, inst_valid} !== {1'b1, exp_pc, 1'b0}) begin
      failures++; $display("FAIL redir_target got=%h exp=%h", {imem_req, imem_addr, inst_valid}, {1'b1, exp_pc, 1'b0});
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      int unsigned waits, stall;
      logic        sel;
      logic [31:0] r, alu;
      waits = $urandom_range(0, 3);
      stall = $urandom_range(0, 2);
      sel   = 1'($urandom_range(0, 1));
      r     = $urandom;
      alu   = r & ~32'd2;
      for (int w = 0; w <= int'(waits); w++) begin
        checks++;
        if ({imem_req, imem_addr, inst_valid, inst} !== {1'b1, exp_pc, 1'b0, exp_inst}) begin
          failures++; $display("FAIL rnd_fetch got=%h exp=%h", {imem_req, imem_addr, inst_valid, inst}, {1'b1, exp_pc, 1'b0, exp_inst});
        end
        imem_ack = (w == int'(waits));
        imem_rdata = (w == int'(waits)) ? mem_word(exp_pc) : $urandom;
        inst_ready = 1'($urandom_range(0, 1));
        tick();
      end
      exp_inst = mem_word(exp_pc);
      for (int s = 0; s <= int'(stall); s++) begin
        checks++;
        if ({inst_valid, imem_req, inst, pc} !== {1'b1, 1'b0, exp_inst, exp_pc}) begin
          failures++; $display("FAIL rnd_valid got=%h exp=%h", {inst_valid, imem_req, inst, pc}, {1'b1, 1'b0, exp_inst, exp_pc});
        end
        imem_ack = 1'($urandom_range(0, 1)); imem_rdata = $urandom;
        inst_ready = (s == int'(stall));
        PCSel = (s == int'(stall)) ? sel : 1'($urandom_range(0, 1));
        alu_target = (s == int'(stall)) ? alu : $urandom;
        tick();
      end
      imem_ack = 1'b0; inst_ready = 1'b0;
      exp_pc = sel ? (alu & ~32'd1) : exp_pc + 32'd4;
    end
  endtask

  task automatic test_misalign();
    imem_ack = 1'b1; imem_rdata = mem_word(exp_pc);
    tick();
    imem_ack = 1'b0; exp_inst = mem_word(exp_pc);
    inst_ready = 1'b1; PCSel = 1'b1; alu_target = 32'h0000_0206;
    tick();
    inst_ready = 1'b0; PCSel = 1'b0;
`ifdef INST_FETCH_MISALIGN_TRAP_EN
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({fetch_fault, imem_req, inst_valid, pc} !== {1'b1, 1'b0, 1'b0, 32'h0000_0206}) begin
        failures++; $display("FAIL mis_fault got=%h exp=%h", {fetch_fault, imem_req, inst_valid, pc}, {1'b1, 1'b0, 1'b0, 32'h0000_0206});
      end
      imem_ack = 1'b1; imem_rdata = $urandom; inst_ready = 1'b1;
      tick();
    end
    imem_ack = 1'b0; inst_ready = 1'b0;
    rst = 1'b1;
    tick();
    checks++;
    if ({fetch_fault, imem_req, pc} !== {1'b0, 1'b0, 32'h0}) begin
      failures++; $display("FAIL mis_reset got=%h exp=%h", {fetch_fault, imem_req, pc}, {1'b0, 1'b0, 32'h0});
    end
    rst = 1'b0;
    tick();
    exp_pc = 32'h0; exp_inst = 32'h0000_0013;
`else
    checks++;
    if ({imem_req, imem_addr, inst_valid, fetch_fault} !== {1'b1, 32'h0000_0204, 1'b0, 1'b0}) begin
      failures++; $display("FAIL mis_align got=%h exp=%h", {imem_req, imem_addr, inst_valid, fetch_fault}, {1'b1, 32'h0000_0204, 1'b0, 1'b0});
    end
    exp_pc = 32'h0000_0204;
`endif
  endtask

  task automatic test_reset_ack();
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hCAFE_BABE;
    tick();
    rst = 1'b0; imem_ack = 1'b0;
    checks++;
    if ({imem_req, inst_valid, fetch_fault, inst, pc} !== {3'b000, 32'h0000_0013, 32'h0}) begin
      failures++; $display("FAIL rst_ack got=%h exp=%h", {imem_req, inst_valid, fetch_fault, inst, pc}, {3'b000, 32'h0000_0013, 32'h0});
    end
    tick();
    imem_ack = 1'b1; imem_rdata = mem_word(32'h0);
    tick();
    imem_ack = 1'b0;
    rst = 1'b1; inst_ready = 1'b1; PCSel = 1'b1; alu_target = 32'h0000_0400;
    tick();
    rst = 1'b0; inst_ready = 1'b0; PCSel = 1'b0;
    checks++;
    if ({imem_req, inst_valid, inst, pc} !== {2'b00, 32'h0000_0013, 32'h0}) begin
      failures++; $display("FAIL rst_handshake got=%h exp=%h", {imem_req, inst_valid, inst, pc}, {2'b00, 32'h0000_0013, 32'h0});
    end
    tick();
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      failures++; $display("FAIL rst_refetch got=%h exp=%h", {imem_req, imem_addr}, {1'b1, 32'h0});
    end
  endtask

  task automatic test_wrap();
    checks++;
    if ({req2, pc2} !== {1'b0, 32'hFFFF_FFFC}) begin
      failures++; $display("FAIL wrap_reset got=%h exp=%h", {req2, pc2}, {1'b0, 32'hFFFF_FFFC});
    end
    rst2 = 1'b0;
    tick();
    checks++;
    if ({req2, addr2} !== {1'b1, 32'hFFFF_FFFC}) begin
      failures++; $display("FAIL wrap_req got=%h exp=%h", {req2, addr2}, {1'b1, 32'hFFFF_FFFC});
    end
    ack2 = 1'b1; rdata2 = mem_word(32'hFFFF_FFFC);
    tick();
    ack2 = 1'b0;
    checks++;
    if ({valid2, inst2, fault2} !== {1'b1, mem_word(32'hFFFF_FFFC), 1'b0}) begin
      failures++; $display("FAIL wrap_valid got=%h exp=%h", {valid2, inst2, fault2}, {1'b1, mem_word(32'hFFFF_FFFC), 1'b0});
    end
    ready2 = 1'b1; sel2 = 1'b0;
    tick();
    ready2 = 1'b0;
    checks++;
    if ({req2, addr2, valid2} !== {1'b1, 32'h0, 1'b0}) begin
      failures++; $display("FAIL wrap_next got=%h exp=%h", {req2, addr2, valid2}, {1'b1, 32'h0, 1'b0});
    end
  endtask

  initial begin
    rst2 = 1'b1; ack2 = 1'b0; rdata2 = 32'h0; ready2 = 1'b0; sel2 = 1'b0; alu2 = 32'h0;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_backpressure();
    test_redirect();
    test_random();
    test_misalign();
    test_reset_ack();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
